mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//   Memory-stage sequencer for the 5-stage pipeline. Watches the memory-control bits of the EX/MEM register.
//   Drives a multi-cycle data memory over a req/ack handshake.
//   Holds stall_o high to freeze every pipeline register (EX/MEM included) until the access completes or times out.
//   Returns latched load data toward MEM/WB.
// PARAMETERS
//   ADDR_W   32   memory address width
//   DATA_W   32   memory data width
//   TIMEOUT  255  max ACCESS cycles waiting for mem_ack_i before abort (>=1)
//   CNT_W    32   width of stall counter (MEM_STALL_CNT_EN only)
// PORTS
//   clk_i        in   1       clock; all state updates on posedge
//   rst_i        in   1       synchronous reset, active-high
//   m_i          in   2       memory ctrl from EX/MEM: [1]=MemRead, [0]=MemWrite
//   addr_i       in   ADDR_W  ALU result from EX/MEM (address)
//   wdata_i      in   DATA_W  store data from EX/MEM
//   mem_req_o    out  1       request to data memory
//   mem_we_o     out  1       1=write, 0=read; valid while mem_req_o=1
//   mem_addr_o   out  ADDR_W  registered request address
//   mem_wdata_o  out  DATA_W  registered store data
//   mem_ack_i    in   1       memory completion strobe
//   mem_rdata_i  in   DATA_W  read data; valid with mem_ack_i
//   rdata_o      out  DATA_W  latched load data toward MEM/WB
//   stall_o      out  1       freeze all pipeline registers
//   err_o        out  1       sticky timeout flag
//   stall_cnt_o  out  CNT_W   stall-cycle count (MEM_STALL_CNT_EN only)
// BEHAVIOUR
//   Reset (rst_i=1 at posedge):
//     - state->IDLE; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o, timeout cnt, stall_cnt_o all cleared to 0.
//     - stall_o forced 0 while rst_i=1.
//     - Reset mid-ACCESS drops mem_req_o on the next edge.
//   FSM IDLE / ACCESS / DONE. stall_o = (IDLE & m_i!=0) | ACCESS (combinational).
//   IDLE:
//     - m_i!=0 -> ACCESS. Register addr_i->mem_addr_o and wdata_i->mem_wdata_o.
//     - Set mem_we_o = m_i==2'b01; m_i==2'b11 is treated as a read (we=0).
//     - Set mem_req_o=1 and clear the timeout cnt.
//   ACCESS:
//     - mem_req_o/we/addr/wdata held stable; timeout cnt increments each cycle.
//     - mem_ack_i=1 -> DONE, drop req; on read latch mem_rdata_i->rdata_o. Writes leave rdata_o unchanged.
//     - No ack and cnt reaches TIMEOUT-1 -> DONE, drop req, err_o<=1, rdata_o<=0.
//     - If ack arrives in that same cycle, the ack wins: normal completion, no error.
//   DONE:
//     - stall_o=0 for exactly one cycle so the pipeline advances; always -> IDLE.
//     - The next op is detected in IDLE, so back-to-back memory ops each take a full sequence.
//   Latency:
//     - Ack in first ACCESS cycle -> stall_o high 2 cycles, DONE on 3rd.
//     - Each extra wait cycle adds 1 stall cycle.
//   mem_ack_i outside ACCESS is ignored. err_o is cleared only by rst_i.
// CONFIGURATION
//   MEM_STALL_CNT_EN defined:
//     - stall_cnt_o present; +1 every cycle stall_o=1; saturates at all-ones; reset to 0.
//   MEM_STALL_CNT_EN undefined:
//     - port and counter absent; all other behaviour identical.
// TESTING
//   1. Zero-wait load:
//      - m_i=10, addr_i=0x40, ack in 1st ACCESS cycle with rdata 0xDEADBEEF
//      - -> req 1 cycle, we=0, stall 2 cycles, rdata_o=0xDEADBEEF in DONE.
//   2. Delayed store:
//      - m_i=01, addr 0x80, wdata 0x12345678, ack 3 cycles after req
//      - -> req/addr/wdata stable 4 cycles, we=1, stall 5 cycles.
//   3. Back-to-back load then store, both zero-wait
//      - -> two IDLE/ACCESS/DONE sequences, stall_o low only in each DONE cycle.
//   4. Timeout, TIMEOUT=8, no ack
//      - -> req drops after 8 ACCESS cycles, err_o=1 and stays 1, rdata_o=0.
//      - A following zero-wait op completes normally with err_o still 1.
//   5. rst_i pulsed in 2nd ACCESS cycle
//      - -> next edge req=0, state IDLE, err_o=0, rdata_o=0.
//      - A late ack after reset is ignored.
//   6. MEM_STALL_CNT_EN, CNT_W=4:
//      - test 2 -> stall_cnt_o=5.
//      - Preloaded near wrap -> holds at 4'hF.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage req/ack sequencer with pipeline stall and timeout; MEM_STALL_CNT_EN adds a saturating stall counter
module mem_stage_ctrl #(
  parameter ADDR_W = 32,
  parameter DATA_W = 32,
  parameter TIMEOUT = 255
`ifdef MEM_STALL_CNT_EN
  , parameter CNT_W = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        m_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
`ifdef MEM_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
`endif
  output logic              err_o
);
  localparam TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  logic [1:0]    r_state;
  logic [TW-1:0] r_cnt;
  logic          w_stall;
  assign w_stall = !rst_i && ((r_state == IDLE && m_i != 2'b00) || r_state == ACCESS);
  assign stall_o = w_stall;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
    end else if (r_state == IDLE) begin
      if (m_i != 2'b00) begin
        r_state     <= ACCESS;
        mem_addr_o  <= addr_i;
        mem_wdata_o <= wdata_i;
        mem_we_o    <= m_i == 2'b01;
        mem_req_o   <= 1'b1;
        r_cnt       <= '0;
      end
    end else if (r_state == ACCESS) begin
      // ack beats a simultaneous timeout
      if (mem_ack_i) begin
        r_state   <= DONE;
        mem_req_o <= 1'b0;
        if (!mem_we_o) rdata_o <= mem_rdata_i;
      end else if (r_cnt == TW'(TIMEOUT - 1)) begin
        r_state   <= DONE;
        mem_req_o <= 1'b0;
        err_o     <= 1'b1;
        rdata_o   <= '0;
      end else begin
        r_cnt <= r_cnt + TW'(1);
      end
    end else begin
      r_state <= IDLE;
    end
  end
`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (w_stall && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end
`endif
endmodule
